// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter for the shared user IO bus. One requester owns the
// pins at a time; ownership is bounded under contention and every owner
// change passes through all-tristate turnaround cycles.
module io_bus_arbiter #(
  parameter int NUM_IO     = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_HOLD   = 16,
  parameter int TURNAROUND = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*NUM_IO-1:0] req_out,
  input  logic [NUM_REQ*NUM_IO-1:0] req_oeb,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  input  logic [NUM_IO-1:0]         io_in,
  output logic [NUM_IO-1:0]         in_data,
  output logic [NUM_IO-1:0]         io_out,
  output logic [NUM_IO-1:0]         io_oeb
);

  localparam int PW = (NUM_REQ    > 1) ? $clog2(NUM_REQ)    : 1;
  localparam int HW = (MAX_HOLD   > 1) ? $clog2(MAX_HOLD)   : 1;
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] tcnt;

  logic               any_req;
  logic [PW-1:0]      win;
  logic [PW-1:0]      cand;
  logic [PW-1:0]      ptr_nxt;
  logic [NUM_REQ-1:0] win_oh;
  int                 idx;

  // Rotating priority search starting at ptr; first requester found wins.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    cand    = '0;
    idx     = 0;
    win_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx  = (int'(ptr) + i) % NUM_REQ;
      cand = PW'(idx);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
    win_oh[win] = 1'b1;
    ptr_nxt     = (win == PW'(NUM_REQ-1)) ? '0 : win + 1'b1;
  end

  logic owner_req, competing, hold_max, turn_last;
  assign owner_req = |(req & grant);
  assign competing = |(req & ~grant);
  assign hold_max  = (hold_cnt == HW'(MAX_HOLD-1));
  assign turn_last = (tcnt == TW'(TURNAROUND-1));
  assign busy      = (state != IDLE);

  // Ownership FSM; pad input is sampled every cycle independent of state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      tcnt     <= '0;
      in_data  <= '0;
    end else begin
      in_data <= io_in;
      case (state)
        IDLE: if (any_req) begin
          state    <= OWN;
          grant    <= win_oh;
          ptr      <= ptr_nxt;
          hold_cnt <= '0;
        end
        OWN: begin
          if (!owner_req || (hold_max && competing)) begin
            state <= TURN;
            grant <= '0;
            tcnt  <= '0;
          end else if (!hold_max) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        TURN: begin
          if (turn_last) begin
            if (any_req) begin
              state    <= OWN;
              grant    <= win_oh;
              ptr      <= ptr_nxt;
              hold_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-lane gating: a non-owner contributes constants, so X on its
  // out/oeb can never reach the pads.
  logic [NUM_REQ-1:0][NUM_IO-1:0] out_term, oeb_term;
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_lane
    assign out_term[r] = grant[r] ? req_out[r*NUM_IO +: NUM_IO] : '0;
    assign oeb_term[r] = grant[r] ? req_oeb[r*NUM_IO +: NUM_IO] : '1;
  end

  // Merge lanes; with no owner this yields io_out=0, io_oeb=all ones.
  always_comb begin
    io_out = '0;
    io_oeb = '1;
    for (int r = 0; r < NUM_REQ; r++) begin
      io_out = io_out | out_term[r];
      io_oeb = io_oeb & oeb_term[r];
    end
  end

endmodule
